// File: rtl/gp_arb_pkg.sv
// Shared types and helpers for the AHB transaction arbiter.
//   arb_state_t : arbiter FSM state encoding
//   MAX_REQ     : largest supported requester count
//   IDX_W       : requester index width, sized for MAX_REQ so the same tag
//                 width serves every legal N_REQ (2..8)
//   rr_first()  : round-robin first-eligible search starting at ptr
package gp_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // Only the first n entries of elig are considered; the search visits
  // ptr, ptr+1, ... wrapping modulo n and keeps the first hit.
  function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] elig,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 n);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (!res.found && elig[k]) begin
          res.found = 1'b1;
          res.idx   = k[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_rd_tag_fifo.sv
// In-order FIFO of requester indices for reads issued but not yet returned.
// Ports:
//   i_clk_ahb, i_rstn_ahb : clock, async active-low reset
//   push, push_data       : enqueue a requester index
//   pop                   : dequeue the head (ignored when empty)
//   head                  : current head entry (valid when !empty)
//   full, empty           : occupancy flags
module ahb_rd_tag_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clk_ahb,
  input  logic             i_rstn_ahb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves this cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_txn_arbiter.sv
// Round-robin arbiter sharing one AHB master transaction port between
// N_REQ requesters, with in-order routing of read returns.
// Ports:
//   i_clk_ahb, i_rstn_ahb            : clock, async active-low reset
//   i_req_valid/rd0_wr1/addr/wr_data : per-requester transaction (packed)
//   o_req_ready                      : one-hot accept to the granted requester
//   o_req_rd_valid, o_req_rd_data    : one-hot read strobe, broadcast data
//   o_m_valid/rd0_wr1/addr/wr_data   : transaction to the AHB master
//   i_m_ready                        : master accept
//   i_m_rd_valid, i_m_rd_data        : read return from the master
//   o_err                            : sticky, read returned with no tag
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | pick a winner each cycle; an accepted winner completes at once
// HOLD  | master stalled: mux locked to grant_q until accept or valid drop
module ahb_txn_arbiter
  import gp_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int RD_OUTSTANDING = 2
) (
  input  logic                          i_clk_ahb,
  input  logic                          i_rstn_ahb,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ-1:0]              i_req_rd0_wr1,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic [N_REQ-1:0]              o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]         o_req_rd_data,
  output logic                          o_m_valid,
  output logic                          o_m_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]         o_m_addr,
  output logic [DATA_WIDTH-1:0]         o_m_wr_data,
  input  logic                          i_m_ready,
  input  logic                          i_m_rd_valid,
  input  logic [DATA_WIDTH-1:0]         i_m_rd_data,
  output logic                          o_err
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] sel, rr_next;
  logic [MAX_REQ-1:0] valid_ext, elig_ext;
  rr_pick_t         pick;
  logic             accept;
  logic             err_q;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W-1:0] fifo_head;

  // A read is only eligible while a tag slot is free; writes never wait
  // on the FIFO.
  always_comb begin
    valid_ext = '0;
    elig_ext  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      valid_ext[k] = i_req_valid[k];
      elig_ext[k]  = i_req_valid[k] && (i_req_rd0_wr1[k] || !fifo_full);
    end
    pick = rr_first(elig_ext, rr_ptr_q, N_REQ);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;

    sel       = (state_q == HOLD) ? grant_q : pick.idx;
    o_m_valid = (state_q == HOLD) ? valid_ext[grant_q] : pick.found;

    // Fields are zeroed when nothing is offered so idle buses stay quiet.
    o_m_rd0_wr1 = 1'b0;
    o_m_addr    = '0;
    o_m_wr_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (o_m_valid && (sel == IDX_W'(k))) begin
        o_m_rd0_wr1 = i_req_rd0_wr1[k];
        o_m_addr    = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        o_m_wr_data = i_req_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    accept = o_m_valid && i_m_ready;

    o_req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_req_ready[k] = accept && (sel == IDX_W'(k));
    end

    rr_next   = (int'(sel) == N_REQ - 1) ? '0 : sel + IDX_W'(1);
    fifo_push = accept && !o_m_rd0_wr1;

    case (state_q)
      ARB: begin
        if (accept) begin
          rr_ptr_d = rr_next;
        end else if (pick.found) begin
          state_d = HOLD;
          grant_d = pick.idx;
        end
      end
      HOLD: begin
        if (accept) begin
          rr_ptr_d = rr_next;
          state_d  = ARB;
        end else if (!valid_ext[grant_q]) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    fifo_pop       = i_m_rd_valid && !fifo_empty;
    o_req_rd_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_req_rd_valid[k] = fifo_pop && (fifo_head == IDX_W'(k));
    end
    o_req_rd_data = fifo_pop ? i_m_rd_data : '0;
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (i_m_rd_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign o_err = err_q;

  ahb_rd_tag_fifo #(
    .DEPTH (RD_OUTSTANDING),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .i_clk_ahb  (i_clk_ahb),
    .i_rstn_ahb (i_rstn_ahb),
    .push       (fifo_push),
    .push_data  (sel),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

endmodule

// File: tb/tb_ahb_txn_arbiter.sv
module tb_ahb_txn_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NR-1:0]  req_valid, req_wr;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_ready, req_rd_valid;
  logic [DW-1:0]  req_rd_data;
  logic           m_valid, m_wr;
  logic [AW-1:0]  m_addr;
  logic [DW-1:0]  m_wr_data;
  logic           m_ready, m_rd_valid;
  logic [DW-1:0]  m_rd_data;
  logic           err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ahb_txn_arbiter #(
    .N_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_OUTSTANDING(2)
  ) dut (
    .i_clk_ahb      (clk),
    .i_rstn_ahb     (rstn),
    .i_req_valid    (req_valid),
    .i_req_rd0_wr1  (req_wr),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_data),
    .o_req_ready    (req_ready),
    .o_req_rd_valid (req_rd_valid),
    .o_req_rd_data  (req_rd_data),
    .o_m_valid      (m_valid),
    .o_m_rd0_wr1    (m_wr),
    .o_m_addr       (m_addr),
    .o_m_wr_data    (m_wr_data),
    .i_m_ready      (m_ready),
    .i_m_rd_valid   (m_rd_valid),
    .i_m_rd_data    (m_rd_data),
    .o_err          (err)
  );

  task automatic idle_inputs();
    req_valid  = '0;
    req_wr     = '0;
    req_addr   = '0;
    req_data   = '0;
    m_ready    = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_data  = '0;
  endtask

  task automatic set_req(input int k, input logic v, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]         = v;
    req_wr[k]            = wr;
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #12;
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    n_vec++; if (req_rd_valid !== 4'b0000) begin n_err++; $display("FAIL rst_rd_valid: got %b want 0000", req_rd_valid); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
    apply_reset();
  endtask

  task automatic test_single_write();
    apply_reset();
    set_req(1, 1'b1, 1'b1, 32'h100, 32'hA5A5_0001);
    m_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (m_addr !== 32'h100) begin n_err++; $display("FAIL sw_addr: got %h want 00000100", m_addr); end
    n_vec++; if (m_wr_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL sw_data: got %h want a5a50001", m_wr_data); end
    n_vec++; if (m_wr !== 1'b1) begin n_err++; $display("FAIL sw_dir: got %b want 1", m_wr); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL sw_ready: got %b want 0010", req_ready); end
    next_cycle();
    // rr_ptr should now be 2: with everyone asking, requester 2 wins.
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b1, 32'h300 + 32'(k), 32'h0);
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL sw_rrptr: got %b want 0100", req_ready); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_rr_writes();
    logic [NR-1:0] want;
    logic [AW-1:0] want_addr;
    apply_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b1, 1'b1, 32'h1000 + 32'(k * 16), 32'hD000 + 32'(k));
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want      = 4'b0001 << (i % 4);
      want_addr = 32'h1000 + 32'((i % 4) * 16);
      @(negedge clk);
      n_vec++; if (req_ready !== want) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, want); end
      n_vec++; if (m_addr !== want_addr) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", i, m_addr, want_addr); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_hold();
    apply_reset();
    set_req(2, 1'b1, 1'b0, 32'h200, 32'h0);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (m_addr !== 32'h200 || m_valid !== 1'b1) begin n_err++; $display("FAIL hold_addr[%0d]: got %h/%b want 00000200/1", i, m_addr, m_valid); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0000", i, req_ready); end
      next_cycle();
      set_req(0, 1'b1, 1'b0, 32'h010, 32'h0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL hold_accept: got %b want 0100", req_ready); end
    n_vec++; if (m_wr !== 1'b0) begin n_err++; $display("FAIL hold_dir: got %b want 0", m_wr); end
    next_cycle();
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001 || m_addr !== 32'h010) begin n_err++; $display("FAIL hold_wrap: got %b/%h want 0001/00000010", req_ready, m_addr); end
    next_cycle();
    idle_inputs();
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h22;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0100 || req_rd_data !== 32'h22) begin n_err++; $display("FAIL hold_ret0: got %b/%h want 0100/00000022", req_rd_valid, req_rd_data); end
    next_cycle();
    m_rd_data = 32'h0A;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0001 || req_rd_data !== 32'h0A) begin n_err++; $display("FAIL hold_ret1: got %b/%h want 0001/0000000a", req_rd_valid, req_rd_data); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic issue_two_reads();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    m_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_issue0: got %b want 0001", req_ready); end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b1000 || m_addr !== 32'h30) begin n_err++; $display("FAIL rd_issue3: got %b/%h want 1000/00000030", req_ready, m_addr); end
    next_cycle();
    set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_read_return();
    apply_reset();
    issue_two_reads();
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h11;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0001 || req_rd_data !== 32'h11) begin n_err++; $display("FAIL ret_0: got %b/%h want 0001/00000011", req_rd_valid, req_rd_data); end
    next_cycle();
    // Pop of tag 3 and push of a new read from req1 in the same cycle.
    m_rd_data = 32'h33;
    set_req(1, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b1000 || req_rd_data !== 32'h33) begin n_err++; $display("FAIL ret_3: got %b/%h want 1000/00000033", req_rd_valid, req_rd_data); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ret_pushpop: got %b want 0010", req_ready); end
    next_cycle();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    m_rd_data = 32'h44;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0010 || req_rd_data !== 32'h44) begin n_err++; $display("FAIL ret_1: got %b/%h want 0010/00000044", req_rd_valid, req_rd_data); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_full_fifo();
    apply_reset();
    issue_two_reads();
    set_req(1, 1'b1, 1'b0, 32'h111, 32'h0);
    set_req(2, 1'b1, 1'b1, 32'h222, 32'hBEEF);
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100 || m_addr !== 32'h222) begin n_err++; $display("FAIL full_write: got %b/%h want 0100/00000222", req_ready, m_addr); end
    next_cycle();
    set_req(2, 1'b0, 1'b1, 32'h0, 32'h0);
    @(negedge clk);
    n_vec++; if (m_valid !== 1'b0 || req_ready !== 4'b0000) begin n_err++; $display("FAIL full_block: got %b/%b want 0/0000", m_valid, req_ready); end
    next_cycle();
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h55;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0001 || req_rd_data !== 32'h55) begin n_err++; $display("FAIL full_pop: got %b/%h want 0001/00000055", req_rd_valid, req_rd_data); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL full_popcyc: got %b want 0", m_valid); end
    next_cycle();
    m_rd_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0010 || m_addr !== 32'h111) begin n_err++; $display("FAIL full_release: got %b/%h want 0010/00000111", req_ready, m_addr); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_err_and_reset();
    apply_reset();
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h99;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0000 || err !== 1'b0) begin n_err++; $display("FAIL err_nostrobe: got %b/%b want 0000/0", req_rd_valid, err); end
    next_cycle();
    m_rd_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b want 1", err); end
      next_cycle();
    end
    set_req(1, 1'b1, 1'b0, 32'h100, 32'h0);
    m_ready = 1'b1;
    next_cycle();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b1, 1'b0, 32'h200, 32'h0);
    m_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    n_vec++; if (m_valid !== 1'b1 || m_addr !== 32'h200) begin n_err++; $display("FAIL err_inhold: got %b/%h want 1/00000200", m_valid, m_addr); end
    idle_inputs();
    rstn = 1'b0;
    #1;
    n_vec++; if (m_valid !== 1'b0 || req_ready !== 4'b0000 || req_rd_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_out: got %b/%b/%b want 0/0000/0000", m_valid, req_ready, req_rd_valid); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", err); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    next_cycle();
    // The read from req1 was in flight; its late return must find no tag.
    m_rd_valid = 1'b1;
    m_rd_data  = 32'h77;
    @(negedge clk);
    n_vec++; if (req_rd_valid !== 4'b0000) begin n_err++; $display("FAIL midrst_fifo: got %b want 0000", req_rd_valid); end
    next_cycle();
    m_rd_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL midrst_late: got %b want 1", err); end
    next_cycle();
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_rr_writes();
    test_hold();
    test_read_return();
    test_full_fifo();
    test_err_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
